// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable BCD MM:SS down-counter. It counts from a user-set time down to
// 00:00, one step per 1 Hz TICK. On reaching zero it pulses DONE for one
// clock and raises ALARM for ALARM_SECS ticks. It is the decrementing
// counterpart of the clock's up-counting digit chain. A borrow ripples from
// the seconds units up to the minutes tens.
//
// Ports:
//   CP                      system clock; all state changes on the rising edge
//   nCLR                    asynchronous active-low reset
//   TICK                    1 Hz enable, one CP cycle wide
//   LOAD                    load LD_* digits; ignored while running
//   LD_M1/LD_M0/LD_S1/LD_S0 load value, BCD; clamped to a legal time on load
//   START                   begin or resume counting from a non-zero value
//   STOP                    pause counting, or silence the alarm
//   M1/M0/S1/S0             remaining time, BCD, registered
//   RUNNING                 high while counting
//   DONE                    one-cycle pulse on the expiry edge
//   ALARM                   high while ringing
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       CP,
  input  logic       nCLR,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic [3:0] LD_M1,
  input  logic [3:0] LD_M0,
  input  logic [3:0] LD_S1,
  input  logic [3:0] LD_S0,
  input  logic       START,
  input  logic       STOP,
  output logic [3:0] M1,
  output logic [3:0] M0,
  output logic [3:0] S1,
  output logic [3:0] S0,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RING} state_t;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam logic [5:0] LAST_CNT = 6'(ALARM_SECS - 1);
  localparam bcd_time_t  T_ZERO   = '0;
  localparam bcd_time_t  T_ONE    = bcd_time_t'(16'h0001);

  state_t    state_q, state_d;
  bcd_time_t time_q,  time_d;
  logic      done_q,  done_d;
  logic [5:0] cnt_q,  cnt_d;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                             input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // One-second BCD decrement. A digit at zero wraps to its maximum and
  // borrows from the next digit up. The minutes tens cannot underflow,
  // because 00:00 is never decremented.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s0 != 4'd0) r.s0 = t.s0 - 4'd1;
    else begin
      r.s0 = 4'd9;
      if (t.s1 != 4'd0) r.s1 = t.s1 - 4'd1;
      else begin
        r.s1 = 4'd5;
        if (t.m0 != 4'd0) r.m0 = t.m0 - 4'd1;
        else begin
          r.m0 = 4'd9;
          r.m1 = t.m1 - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before this edge. Blocking assignments
  // here would create order-dependent races between the registers.
  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      state_q <= IDLE;
      time_q  <= T_ZERO;
      done_q  <= 1'b0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event priority: LOAD > STOP > START > TICK. A LOAD that arrives while
  // running is ignored entirely, so lower-priority events still apply.
  always_comb begin
    // NOTE: every next-state signal gets a hold value first. Any path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    if (LOAD && state_q != RUN) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
      time_d  = '{m1: clamp_digit(LD_M1, 4'd5), m0: clamp_digit(LD_M0, 4'd9),
                  s1: clamp_digit(LD_S1, 4'd5), s0: clamp_digit(LD_S0, 4'd9)};
    end else if (STOP) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end else if (state_q == RING) begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    end else if (START) begin
      // A START cycle never decrements, even if TICK arrives with it.
      if ((state_q == IDLE || state_q == PAUSE) && time_q != T_ZERO)
        state_d = RUN;
    end else if (TICK) begin
      if (state_q == RUN) begin
        if (time_q == T_ONE) begin
          time_d  = T_ZERO;
          state_d = RING;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
        end else begin
          time_d = bcd_dec(time_q);
        end
      end else if (state_q == RING) begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
    end
  end

  assign M1      = time_q.m1;
  assign M0      = time_q.m0;
  assign S1      = time_q.s1;
  assign S0      = time_q.s0;
  assign RUNNING = (state_q == RUN);
  assign ALARM   = (state_q == RING);
  assign DONE    = done_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable BCD MM:SS down-counter for the clock design, counting down from a user-set time to 00:00 on the 1 Hz enable.
- It is the decrementing counterpart of the clock's up-counting digit chain: borrow ripples from seconds units up to minutes tens.
- On reaching zero it pulses DONE and holds ALARM for a programmable number of seconds.
- Sits beside the timekeeping counters and shares their 1 Hz tick and display digit format.

Parameters:
ALARM_SECS, 10, number of TICK pulses ALARM stays high after expiry (1..63)

Ports:
CP  input  1  system clock; all state changes on rising edge
nCLR  input  1  asynchronous active-low reset
TICK  input  1  1 Hz enable, high for exactly one CP cycle per second
LOAD  input  1  load LD_* digits (level sampled each CP edge)
LD_M1  input  4  load value, minutes tens (BCD)
LD_M0  input  4  load value, minutes units (BCD)
LD_S1  input  4  load value, seconds tens (BCD)
LD_S0  input  4  load value, seconds units (BCD)
START  input  1  begin/resume counting
STOP  input  1  pause counting / silence alarm
M1, M0, S1, S0  output  4 each  current remaining time, BCD
RUNNING  output  1  high while state is RUN
DONE  output  1  one-CP-cycle pulse on expiry
ALARM  output  1  high during RING state

Behaviour:
- Reset (nCLR low, asynchronous): all digits 0, state IDLE, RUNNING=0, DONE=0, ALARM=0, alarm tick count 0. Reset mid-count or mid-ring aborts immediately.
- All outputs are registered. Digits change on the CP edge where the event is sampled; no combinational path from inputs to outputs.
- States: IDLE, RUN, PAUSE, RING. RUNNING=(state==RUN); ALARM=(state==RING).
- Event priority within one cycle: LOAD > STOP > START > TICK.
- LOAD:
  - Accepted in IDLE, PAUSE and RING; ignored in RUN.
  - Next state is IDLE; clears ALARM and the alarm count.
  - Digit clamping on load: any digit >9 loads as 9; S1 >5 and M1 >5 load as 5. Example: load 7,12,9,3 -> 5,9,5,3.
- START:
  - In IDLE or PAUSE with value != 00:00 -> RUN.
  - With value 00:00, or in RUN or RING: ignored.
  - A TICK sampled in the same cycle as START does not decrement.
- STOP:
  - RUN -> PAUSE, digits held.
  - RING -> IDLE, ALARM low next cycle.
  - IDLE/PAUSE: no effect.
  - STOP with TICK in RUN: no decrement.
- RUN decrement on TICK, BCD borrow chain:
  - S0: 1..9 -> S0-1; 0 -> 9 with borrow.
  - S1 on borrow: 1..5 -> S1-1; 0 -> 5 with borrow.
  - M0 on borrow: 1..9 -> M0-1; 0 -> 9 with borrow.
  - M1 on borrow: M1-1. Never underflows, because value 00:00 is never decremented.
  - Examples: 10:00 -> 09:59; 01:00 -> 00:59.
- Expiry: TICK in RUN with value 00:01 -> digits 00:00, state RING, DONE=1 for that one cycle, ALARM=1, alarm count cleared.
- RING:
  - Each TICK increments the alarm count.
  - On the ALARM_SECS-th TICK -> IDLE, ALARM=0, alarm count cleared.
  - Digits stay 00:00.
- DONE is high only on the expiry cycle; otherwise 0.
- TICK outside RUN/RING has no effect. Digits are frozen in IDLE, PAUSE and RING except on LOAD.
- Digits never leave the legal BCD range: S1,M1 in 0..5; S0,M0 in 0..9.

Test Plan:
- Reset mid-RUN at 03:27 -> next edge digits 00:00, RUNNING=0, ALARM=0; TICKs ignored until LOAD+START.
- LOAD 01:00, START, 1 TICK -> 00:59; 59 further TICKs -> 00:00, DONE pulses exactly one cycle, ALARM rises on the same edge.
- In RING, ALARM_SECS=10: ALARM stays high for exactly 10 TICKs, then state IDLE; STOP at TICK 3 instead -> ALARM low next cycle.
- LOAD 10:00, START, 1 TICK -> 09:59. LOAD digits 7,12,9,3 -> 59:53 after clamping. START with 00:00 -> RUNNING stays 0.
- RUN at 00:05, STOP and TICK in the same cycle -> PAUSE at 00:05; START and TICK in the same cycle -> RUN at 00:05; next TICK -> 00:04.
- LOAD during RUN at 02:30 -> ignored, count continues; LOAD and START in the same cycle from PAUSE -> IDLE with new digits, not running.
